// File: rtl/basic_search_seq.sv
// CTU full-search sequencer: preload, current-block fetch, raster search, SAD drain.
// Define BASIC_SEARCH_SEQ_BEST_TRACK_EN to build in the best-SAD tracker.
module basic_search_seq #(
    parameter int SEARCH_COLS    = 32,
    parameter int SEARCH_ROWS    = 64,
    parameter int PRELOAD_CYCLES = 8,
    parameter int CUR_ROWS       = 8,
    parameter int SAD_LAT        = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [17:0] sad32x32,
    output logic        busy,
    output logic        ref_begin_prepare,
    output logic        curr_rd_en,
    output logic        pe_begin_prepare,
    output logic [4:0]  search_column_count,
    output logic [6:0]  search_row_count,
    output logic        sad_tag_valid,
    output logic [17:0] best_sad,
    output logic [4:0]  best_col,
    output logic [6:0]  best_row,
    output logic        done
);

    localparam int MAX_A = (PRELOAD_CYCLES > CUR_ROWS) ? PRELOAD_CYCLES : CUR_ROWS;
    localparam int MAX_C = (MAX_A > SAD_LAT) ? MAX_A : SAD_LAT;
    localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRELOAD,
        S_CURLOAD,
        S_SEARCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         col_q, col_d;
    logic [6:0]         row_q, row_d;
    logic               busy_q, busy_d;
    logic               ref_q, ref_d;
    logic               curr_q, curr_d;
    logic               pe_q, pe_d;
    logic               done_q, done_d;

    logic [SAD_LAT-1:0] vld_q, vld_d;
    logic [4:0]         tcol_q [SAD_LAT];
    logic [4:0]         tcol_d [SAD_LAT];
    logic [6:0]         trow_q [SAD_LAT];
    logic [6:0]         trow_d [SAD_LAT];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = '0;
        row_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PRELOAD;
                    cnt_d   = '0;
                end
            end
            S_PRELOAD: begin
                if (cnt_q == CNT_W'(PRELOAD_CYCLES - 1)) begin
                    state_d = S_CURLOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CURLOAD: begin
                if (cnt_q == CNT_W'(CUR_ROWS - 1)) begin
                    state_d = S_SEARCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SEARCH: begin
                // Raster scan: column fastest, row advances on column wrap.
                if (col_q == 5'(SEARCH_COLS - 1)) begin
                    if (row_q == 7'(SEARCH_ROWS - 1)) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        row_d = row_q + 7'd1;
                    end
                end else begin
                    col_d = col_q + 5'd1;
                    row_d = row_q;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_W'(SAD_LAT - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            col_d   = '0;
            row_d   = '0;
        end

        // Outputs are registered, so they are decoded from the next state.
        busy_d = (state_d != S_IDLE);
        ref_d  = (state_d == S_PRELOAD) && (state_q != S_PRELOAD);
        curr_d = (state_d == S_CURLOAD);
        pe_d   = (state_d == S_SEARCH) && (state_q != S_SEARCH);
        done_d = (state_d == S_DONE);
    end

    always_comb begin
        vld_d = '0;
        for (int i = 0; i < SAD_LAT; i++) begin
            tcol_d[i] = '0;
            trow_d[i] = '0;
        end
        if (!abort) begin
            vld_d[0]  = (state_q == S_SEARCH);
            tcol_d[0] = col_q;
            trow_d[0] = row_q;
            for (int i = 1; i < SAD_LAT; i++) begin
                vld_d[i]  = vld_q[i-1];
                tcol_d[i] = tcol_q[i-1];
                trow_d[i] = trow_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            busy_q  <= 1'b0;
            ref_q   <= 1'b0;
            curr_q  <= 1'b0;
            pe_q    <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= '0;
            for (int i = 0; i < SAD_LAT; i++) begin
                tcol_q[i] <= '0;
                trow_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            busy_q  <= busy_d;
            ref_q   <= ref_d;
            curr_q  <= curr_d;
            pe_q    <= pe_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            for (int i = 0; i < SAD_LAT; i++) begin
                tcol_q[i] <= tcol_d[i];
                trow_q[i] <= trow_d[i];
            end
        end
    end

    assign busy                = busy_q;
    assign ref_begin_prepare   = ref_q;
    assign curr_rd_en          = curr_q;
    assign pe_begin_prepare    = pe_q;
    assign search_column_count = col_q;
    assign search_row_count    = row_q;
    assign sad_tag_valid       = vld_q[SAD_LAT-1];
    assign done                = done_q;

`ifdef BASIC_SEARCH_SEQ_BEST_TRACK_EN
    logic [17:0] best_sad_q, best_sad_d;
    logic [4:0]  best_col_q, best_col_d;
    logic [6:0]  best_row_q, best_row_d;

    // Strict less-than keeps the first position on ties; abort freezes the result.
    always_comb begin
        best_sad_d = best_sad_q;
        best_col_d = best_col_q;
        best_row_d = best_row_q;
        if (!abort) begin
            if (state_q == S_IDLE && start) begin
                best_sad_d = 18'h3FFFF;
                best_col_d = '0;
                best_row_d = '0;
            end else if (vld_q[SAD_LAT-1] && (sad32x32 < best_sad_q)) begin
                best_sad_d = sad32x32;
                best_col_d = tcol_q[SAD_LAT-1];
                best_row_d = trow_q[SAD_LAT-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_sad_q <= 18'h3FFFF;
            best_col_q <= '0;
            best_row_q <= '0;
        end else begin
            best_sad_q <= best_sad_d;
            best_col_q <= best_col_d;
            best_row_q <= best_row_d;
        end
    end

    assign best_sad = best_sad_q;
    assign best_col = best_col_q;
    assign best_row = best_row_q;
`else
    logic unused_ok;
    assign unused_ok = ^{sad32x32, tcol_q[SAD_LAT-1], trow_q[SAD_LAT-1]};

    assign best_sad = '0;
    assign best_col = '0;
    assign best_row = '0;
`endif

endmodule

// File: tb/tb_basic_search_seq.sv
// Self-checking bench for basic_search_seq: cycle-exact control timeline plus best-SAD reference model.
module tb_basic_search_seq;

    localparam int COLS   = 32;
    localparam int ROWS   = 64;
    localparam int PRE    = 8;
    localparam int CUR    = 8;
    localparam int LAT    = 3;
    localparam int NPOS   = COLS * ROWS;
    localparam int T_PRE  = 1;
    localparam int T_CUR  = T_PRE + PRE;
    localparam int T_SRCH = T_CUR + CUR;
    localparam int T_DRN  = T_SRCH + NPOS;
    localparam int T_DONE = T_DRN + LAT;
    localparam int NEVER  = 1 << 30;
`ifdef BASIC_SEARCH_SEQ_BEST_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif
    localparam logic [17:0] INIT_BEST = TRACK ? 18'h3FFFF : 18'h0;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [17:0] sad32x32;
    logic        busy;
    logic        ref_begin_prepare;
    logic        curr_rd_en;
    logic        pe_begin_prepare;
    logic [4:0]  search_column_count;
    logic [6:0]  search_row_count;
    logic        sad_tag_valid;
    logic [17:0] best_sad;
    logic [4:0]  best_col;
    logic [6:0]  best_row;
    logic        done;

    basic_search_seq #(
        .SEARCH_COLS    (COLS),
        .SEARCH_ROWS    (ROWS),
        .PRELOAD_CYCLES (PRE),
        .CUR_ROWS       (CUR),
        .SAD_LAT        (LAT)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .abort               (abort),
        .sad32x32            (sad32x32),
        .busy                (busy),
        .ref_begin_prepare   (ref_begin_prepare),
        .curr_rd_en          (curr_rd_en),
        .pe_begin_prepare    (pe_begin_prepare),
        .search_column_count (search_column_count),
        .search_row_count    (search_row_count),
        .sad_tag_valid       (sad_tag_valid),
        .best_sad            (best_sad),
        .best_col            (best_col),
        .best_row            (best_row),
        .done                (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          passes;
    int          fails;
    int          cyc;
    logic [17:0] sads [NPOS];
    logic [17:0] exp_best;
    logic [4:0]  exp_col;
    logic [6:0]  exp_row;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [17:0] obs_ctrl();
        return {busy, ref_begin_prepare, curr_rd_en, pe_begin_prepare,
                search_column_count, search_row_count, sad_tag_valid, done};
    endfunction

    // Timeline derived from phase lengths: PRELOAD, CURLOAD, SEARCH raster, DRAIN, DONE.
    function automatic logic [17:0] exp_ctrl(input int c, input int cut);
        logic       b, rp, cr, pe, v, dn;
        logic [4:0] col;
        logic [6:0] row;
        int         i;
        if (c > cut) return '0;
        b   = (c >= 1) && (c <= T_DONE);
        rp  = (c == T_PRE);
        cr  = (c >= T_CUR) && (c < T_SRCH);
        pe  = (c == T_SRCH);
        col = '0;
        row = '0;
        if (c >= T_SRCH && c < T_DRN) begin
            i   = c - T_SRCH;
            col = 5'(i % COLS);
            row = 7'(i / COLS);
        end
        v  = (c >= T_SRCH + LAT) && (c < T_DRN + LAT);
        dn = (c == T_DONE);
        return {b, rp, cr, pe, col, row, v, dn};
    endfunction

    task automatic step_idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            check("idle_ctrl", 64'(obs_ctrl()), 64'(18'h0));
            check("idle_best", {best_sad, best_col, best_row}, {exp_best, exp_col, exp_row});
        end
    endtask

    // mode 0: full-range random, 1: two equal minima, 2: narrow range with many ties
    task automatic run_search(input int mode, input int abort_c, input int start_c, input int rst_c);
        int cut;
        int stop_c;
        int i;
        cut = NEVER;
        if (abort_c >= 0) cut = abort_c;
        if (rst_c >= 0) cut = rst_c;
        stop_c = (cut == NEVER) ? T_DONE + 1 : cut + 1;
        for (int k = 0; k < NPOS; k++) begin
            case (mode)
                0:       sads[k] = 18'($urandom_range(0, 18'h3FFFE));
                1:       sads[k] = 18'd1000;
                default: sads[k] = 18'($urandom_range(100, 120));
            endcase
        end
        if (mode == 1) begin
            sads[10 * COLS + 5] = 18'd200;
            sads[20 * COLS + 7] = 18'd200;
        end

        cyc      = 0;
        start    = 1'b1;
        abort    = 1'b0;
        sad32x32 = 18'($urandom);
        exp_best = INIT_BEST;
        exp_col  = '0;
        exp_row  = '0;
        $display("run mode=%0d abort=%0d extra_start=%0d reset=%0d", mode, abort_c, start_c, rst_c);

        while (cyc < stop_c) begin
            @(posedge clk);
            #1;
            cyc++;
            check("ctrl", 64'(obs_ctrl()), 64'(exp_ctrl(cyc, cut)));
            check("best", {best_sad, best_col, best_row}, {exp_best, exp_col, exp_row});

            start = (cyc == start_c);
            abort = (cyc == abort_c);
            rst_n = !(cyc == rst_c);
            i = cyc - (T_SRCH + LAT);
            if (i >= 0 && i < NPOS) sad32x32 = sads[i];
            else sad32x32 = 18'($urandom);

            if (cyc == rst_c) begin
                exp_best = INIT_BEST;
                exp_col  = '0;
                exp_row  = '0;
            end else if (cyc != abort_c && TRACK && i >= 0 && i < NPOS && sads[i] < exp_best) begin
                exp_best = sads[i];
                exp_col  = 5'(i % COLS);
                exp_row  = 7'(i / COLS);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b1;
        $display("run end cyc=%0d best_sad=%0d best_col=%0d best_row=%0d", cyc, best_sad, best_col, best_row);
    endtask

    initial begin
        checks   = 0;
        passes   = 0;
        fails    = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        sad32x32 = '0;
        exp_best = INIT_BEST;
        exp_col  = '0;
        exp_row  = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", 64'(obs_ctrl()), 64'(18'h0));
        check("reset_best", {best_sad, best_col, best_row}, {INIT_BEST, 5'd0, 7'd0});
        rst_n = 1'b1;
        step_idle(2);

        run_search(0, -1, -1, -1);
        run_search(1, -1, -1, -1);
        check("two_minima", {best_sad, best_col, best_row},
              TRACK ? {18'd200, 5'd5, 7'd10} : {18'd0, 5'd0, 7'd0});
        run_search(2, 500, -1, -1);
        step_idle(1);
        run_search(2, -1, 100, -1);
        run_search(0, -1, -1, 12);
        check("post_reset_best", {best_sad, best_col, best_row}, {INIT_BEST, 5'd0, 7'd0});
        step_idle(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
